sobel_edge_gen: RTL and testbench

Parametrised Sobel edge generator for the camera-to-SDRAM video path. It sits between the 3x3 line-buffer matrix generator and the SDRAM write FIFO. It computes exact signed Sobel gradients for any pixel width, applies a runtime threshold and display mode that are shadowed at frame boundaries, and emits RGB565 write data. It can also report a per-frame count of edge pixels.

---
 rtl/sobel_edge_gen.sv | 146 ++++++++++++++
 tb/tb_sobel_edge_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_edge_gen.sv
// Three-stage Sobel edge generator producing RGB565 SDRAM write data.
// Optional per-frame edge counter is built only when SOBEL_EDGE_CNT_EN is defined.
module sobel_edge_gen #(
    parameter int DW      = 8,
    parameter int THR_DEF = 12,
    parameter int CNT_W   = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              data_en,
    input  logic [DW-1:0]     p11,
    input  logic [DW-1:0]     p12,
    input  logic [DW-1:0]     p13,
    input  logic [DW-1:0]     p21,
    input  logic [DW-1:0]     p22,
    input  logic [DW-1:0]     p23,
    input  logic [DW-1:0]     p31,
    input  logic [DW-1:0]     p32,
    input  logic [DW-1:0]     p33,
    input  logic [DW+2:0]     thr_in,
    input  logic [1:0]        mode_in,
    output logic              sdram_wr_en,
    output logic [15:0]       sdram_wr_data,
    output logic [CNT_W-1:0]  edge_cnt,
    output logic              edge_cnt_vld
);
    localparam int GW = DW + 3;
    localparam logic [DW-1:0] PMAX = {DW{1'b1}};

    function automatic logic signed [GW-1:0] zx(input logic [DW-1:0] v);
        return $signed({3'b000, v});
    endfunction

    function automatic logic [15:0] pack565(input logic [DW-1:0] v);
        return {v[DW-1-:5], v[DW-1-:6], v[DW-1-:5]};
    endfunction

    logic [GW-1:0]        thr_s_reg;
    logic [1:0]           mode_s_reg;
    logic signed [GW-1:0] gx_reg, gy_reg, gx_next, gy_next;
    logic [GW-1:0]        thr1_reg, thr2_reg;
    logic [1:0]           mode1_reg, mode2_reg;
    logic [DW-1:0]        p22_1_reg, p22_2_reg;
    logic                 v1_reg, v2_reg;
    logic [GW-1:0]        abs_gx, abs_gy, mag_reg, mag_next;
    logic [DW-1:0]        mag_sat;
    logic                 edge_flag;
    logic [15:0]          out_next;
    logic                 wr_en_reg;
    logic [15:0]          wr_data_reg;

    // GW bits hold +/-4*(2^DW-1), so the signed gradients never wrap.
    assign gx_next = (zx(p13) - zx(p11)) + ((zx(p23) - zx(p21)) <<< 1) + (zx(p33) - zx(p31));
    assign gy_next = (zx(p11) - zx(p31)) + ((zx(p12) - zx(p32)) <<< 1) + (zx(p13) - zx(p33));
    assign abs_gx  = gx_reg[GW-1] ? $unsigned(-gx_reg) : $unsigned(gx_reg);
    assign abs_gy  = gy_reg[GW-1] ? $unsigned(-gy_reg) : $unsigned(gy_reg);
    assign mag_next = abs_gx + abs_gy;

    always_comb begin
        mag_sat   = (mag_reg > {3'b000, PMAX}) ? PMAX : mag_reg[DW-1:0];
        edge_flag = (mag_reg > thr2_reg);
        out_next  = 16'h0000;
        case (mode2_reg)
            2'd0:    out_next = edge_flag ? 16'h0000 : 16'hFFFF;
            2'd1:    out_next = edge_flag ? 16'hFFFF : 16'h0000;
            2'd2:    out_next = pack565(mag_sat);
            default: out_next = pack565(p22_2_reg);
        endcase
    end

    // Shadows update after the frame_start cycle, so a pixel accepted alongside it sees old values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_s_reg   <= GW'(THR_DEF);
            mode_s_reg  <= 2'd0;
            gx_reg      <= '0;
            gy_reg      <= '0;
            thr1_reg    <= '0;
            mode1_reg   <= 2'd0;
            p22_1_reg   <= '0;
            v1_reg      <= 1'b0;
            mag_reg     <= '0;
            thr2_reg    <= '0;
            mode2_reg   <= 2'd0;
            p22_2_reg   <= '0;
            v2_reg      <= 1'b0;
            wr_en_reg   <= 1'b0;
            wr_data_reg <= 16'h0000;
        end else begin
            if (frame_start) begin
                thr_s_reg  <= thr_in;
                mode_s_reg <= mode_in;
            end
            v1_reg    <= data_en;
            gx_reg    <= gx_next;
            gy_reg    <= gy_next;
            thr1_reg  <= thr_s_reg;
            mode1_reg <= mode_s_reg;
            p22_1_reg <= p22;
            v2_reg    <= v1_reg;
            mag_reg   <= mag_next;
            thr2_reg  <= thr1_reg;
            mode2_reg <= mode1_reg;
            p22_2_reg <= p22_1_reg;
            wr_en_reg <= v2_reg;
            if (v2_reg)
                wr_data_reg <= out_next;
        end
    end

    assign sdram_wr_en   = wr_en_reg;
    assign sdram_wr_data = wr_data_reg;

`ifdef SOBEL_EDGE_CNT_EN
    logic [CNT_W-1:0] run_reg, cnt_reg;
    logic             cnt_vld_reg;
    logic             count_hit;

    assign count_hit = v2_reg && edge_flag;

    // An edge leaving stage 3 on the frame_start cycle belongs to the new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_reg     <= '0;
            cnt_reg     <= '0;
            cnt_vld_reg <= 1'b0;
        end else begin
            cnt_vld_reg <= frame_start;
            if (frame_start) begin
                cnt_reg <= run_reg;
                run_reg <= {{(CNT_W-1){1'b0}}, count_hit};
            end else if (count_hit && (run_reg != {CNT_W{1'b1}})) begin
                run_reg <= run_reg + 1'b1;
            end
        end
    end

    assign edge_cnt     = cnt_reg;
    assign edge_cnt_vld = cnt_vld_reg;
`else
    assign edge_cnt     = '0;
    assign edge_cnt_vld = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_edge_gen.sv
// Self-checking bench for sobel_edge_gen: directed scenarios plus random streaming
// against an arithmetic reference model of the 3-cycle pipeline.
module tb_sobel_edge_gen;
    localparam int DW      = 8;
    localparam int THR_DEF = 12;
    localparam int CNT_W   = 20;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              frame_start, data_en;
    logic [DW-1:0]     w [9];
    logic [DW+2:0]     thr_in;
    logic [1:0]        mode_in;
    logic              sdram_wr_en;
    logic [15:0]       sdram_wr_data;
    logic [CNT_W-1:0]  edge_cnt;
    logic              edge_cnt_vld;

    sobel_edge_gen #(.DW(DW), .THR_DEF(THR_DEF), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .data_en(data_en),
        .p11(w[0]), .p12(w[1]), .p13(w[2]),
        .p21(w[3]), .p22(w[4]), .p23(w[5]),
        .p31(w[6]), .p32(w[7]), .p33(w[8]),
        .thr_in(thr_in), .mode_in(mode_in),
        .sdram_wr_en(sdram_wr_en), .sdram_wr_data(sdram_wr_data),
        .edge_cnt(edge_cnt), .edge_cnt_vld(edge_cnt_vld)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          thr_m, mode_m, run_m, cnt_m;
    bit          vld_m;
    bit          pe_en   [3];
    bit          pe_edge [3];
    logic [15:0] pe_data [3];
    logic [15:0] last_data;

    function automatic logic [15:0] pk(input int m);
        return 16'(((m >> 3) << 11) | ((m >> 2) << 5) | (m >> 3));
    endfunction

    // Reference: Sobel on plain integers from the current window.
    function automatic void ref_pix(input int thr, input int mode,
                                    output logic [15:0] d, output bit e);
        int v [9];
        int gx, gy, mag, m;
        for (int i = 0; i < 9; i++) v[i] = int'(w[i]);
        gx  = (v[2] - v[0]) + 2 * (v[5] - v[3]) + (v[8] - v[6]);
        gy  = (v[0] - v[6]) + 2 * (v[1] - v[7]) + (v[2] - v[8]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        e   = (mag > thr);
        m   = (mag > 255) ? 255 : mag;
        case (mode)
            0:       d = e ? 16'h0000 : 16'hFFFF;
            1:       d = e ? 16'hFFFF : 16'h0000;
            2:       d = pk(m);
            default: d = pk(v[4]);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        thr_m = THR_DEF; mode_m = 0; run_m = 0; cnt_m = 0; vld_m = 0;
        last_data = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            pe_en[i] = 0; pe_edge[i] = 0; pe_data[i] = 16'h0000;
        end
    endtask

    task automatic step(input bit en, input bit fs);
        logic [15:0] d;
        bit          e;
        bit          leave_edge;
        ref_pix(thr_m, mode_m, d, e);
        data_en     = en;
        frame_start = fs;
        leave_edge  = pe_en[1] && pe_edge[1];
        if (fs) begin
            cnt_m = run_m;
            run_m = leave_edge ? 1 : 0;
            thr_m = int'(thr_in);
            mode_m = int'(mode_in);
        end else if (leave_edge && run_m < CMAX) begin
            run_m++;
        end
        vld_m = fs;
        @(posedge clk);
        #1;
        pe_en[2] = pe_en[1];   pe_data[2] = pe_data[1];   pe_edge[2] = pe_edge[1];
        pe_en[1] = pe_en[0];   pe_data[1] = pe_data[0];   pe_edge[1] = pe_edge[0];
        pe_en[0] = en;         pe_data[0] = d;            pe_edge[0] = e;
        if (pe_en[2]) last_data = pe_data[2];
        check("wr_en", 32'(sdram_wr_en), 32'(pe_en[2]));
        check("wr_data", 32'(sdram_wr_data), 32'(last_data));
`ifdef SOBEL_EDGE_CNT_EN
        check("edge_cnt", 32'(edge_cnt), 32'(cnt_m));
        check("edge_cnt_vld", 32'(edge_cnt_vld), 32'(vld_m));
`else
        check("edge_cnt", 32'(edge_cnt), 32'd0);
        check("edge_cnt_vld", 32'(edge_cnt_vld), 32'd0);
`endif
        data_en     = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic hard_reset();
        rst_n = 1'b0;
        data_en = 1'b0;
        frame_start = 1'b0;
        #2;
        model_clear();
        check("rst_wr_en", 32'(sdram_wr_en), 32'd0);
        check("rst_wr_data", 32'(sdram_wr_data), 32'd0);
        check("rst_edge_cnt", 32'(edge_cnt), 32'd0);
        check("rst_edge_cnt_vld", 32'(edge_cnt_vld), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_all(input int a);
        for (int i = 0; i < 9; i++) w[i] = DW'(a);
    endtask

    task automatic set_cols(input int a, input int b, input int c);
        for (int r = 0; r < 3; r++) begin
            w[3*r] = DW'(a); w[3*r+1] = DW'(b); w[3*r+2] = DW'(c);
        end
    endtask

    // One pixel, then two idle cycles so it is on the output when checked.
    task automatic pix(input bit fs, input string tag, input logic [15:0] exp);
        step(1'b1, fs);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check(tag, 32'(sdram_wr_data), 32'(exp));
    endtask

    task automatic new_frame(input int thr, input int mode);
        thr_in  = (DW+3)'(thr);
        mode_in = 2'(mode);
        step(1'b0, 1'b1);
    endtask

    task automatic rand_steps(input int n);
        bit en, fs;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 9; i++)
                w[i] = ($urandom % 2) ? (($urandom % 2) ? DW'(255) : DW'(0)) : DW'($urandom % 256);
            en = ($urandom % 4) != 0;
            fs = ($urandom % 40) == 0;
            if (fs) begin
                thr_in  = (DW+3)'($urandom % 400);
                mode_in = 2'($urandom % 4);
            end
            step(en, fs);
        end
    endtask

    initial begin
        set_all(0);
        thr_in  = (DW+3)'(THR_DEF);
        mode_in = 2'd0;
        hard_reset();

        set_all(100);
        pix(1'b0, "flat", 16'hFFFF);
        set_cols(0, 0, 255);
        pix(1'b0, "vedge", 16'h0000);
        set_cols(255, 0, 0);
        pix(1'b0, "vedge_mirror", 16'h0000);
        new_frame(THR_DEF, 2);
        pix(1'b0, "vedge_mag_sat", 16'hFFFF);

        // Sobel magnitudes are always even, so 14 is the first value above 12.
        new_frame(THR_DEF, 0);
        set_all(0); w[2] = 8'd6;
        pix(1'b0, "mag_eq_thr", 16'hFFFF);
        w[2] = 8'd7;
        pix(1'b0, "mag_gt_thr", 16'h0000);
        new_frame(THR_DEF, 1);
        w[2] = 8'd6;
        pix(1'b0, "inv_eq_thr", 16'h0000);
        w[2] = 8'd7;
        pix(1'b0, "inv_gt_thr", 16'hFFFF);

        new_frame(THR_DEF, 0);
        thr_in = (DW+3)'(2000);
        set_cols(0, 0, 255);
        pix(1'b0, "thr_midframe", 16'h0000);
        pix(1'b1, "thr_same_cycle", 16'h0000);
        pix(1'b0, "thr_new", 16'hFFFF);

        new_frame(THR_DEF, 3);
        set_all(0); w[4] = 8'hA5;
        pix(1'b0, "pass_through", 16'hA534);

        new_frame(THR_DEF, 0);
        set_cols(0, 0, 255);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        set_all(100);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
`ifdef SOBEL_EDGE_CNT_EN
        check("cnt_ten", 32'(edge_cnt), 32'd10);
        check("cnt_vld_pulse", 32'(edge_cnt_vld), 32'd1);
`else
        check("cnt_ten", 32'(edge_cnt), 32'd0);
        check("cnt_vld_pulse", 32'(edge_cnt_vld), 32'd0);
`endif
        step(1'b0, 1'b0);
        check("cnt_vld_single", 32'(edge_cnt_vld), 32'd0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        rand_steps(200);
        hard_reset();
        rand_steps(200);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
